pixel_uart_sender: RTL and testbench

Frame read-back engine for the VGA serial display. It reads 24-bit pixels from the frame RAM and streams each one to the UART transmitter as three bytes. The byte order matches the receive-side assembler, so a dumped frame re-loads bit-exact. It sits between the frame RAM second read port and the UART TX core, and is started by a one-cycle command pulse.

---
 rtl/pixel_uart_sender.sv | 141 ++++++++++++++
 tb/tb_pixel_uart_sender.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_uart_sender.sv
// Frame read-back engine: streams 24-bit frame RAM pixels to the UART
// as three bytes each, low byte first, matching the receive-side assembler.
module pixel_uart_sender #(
    parameter  int PIXEL_COUNT = 172800,
    localparam int ADDR_BITS   = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 tx_busy,
    input  logic [23:0]          rd_data,
    output logic [ADDR_BITS-1:0] rd_addr,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LATCH,
        SEND,
        WAIT_HI,
        WAIT_LO,
        NEXT,
        FIN
    } state_e;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PIXEL_COUNT - 1);

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [23:0]          pix_q, pix_d;
    logic [1:0]           idx_q, idx_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            pix_q      <= '0;
            idx_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pix_q      <= pix_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pix_d      = pix_q;
        idx_d      = idx_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d = RD;
                    busy_d  = 1'b1;
                end
            end
            RD: begin
                state_d = LATCH;
            end
            LATCH: begin
                pix_d   = rd_data;
                idx_d   = 2'd0;
                state_d = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = WAIT_HI;
                    unique case (idx_q)
                        2'd0:    tx_data_d = pix_q[7:0];
                        2'd1:    tx_data_d = pix_q[15:8];
                        default: tx_data_d = pix_q[23:16];
                    endcase
                end
            end
            WAIT_HI: begin
                // tx_busy rising is the UART's acknowledgement of the byte
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx_q < 2'd2) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = FIN;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = RD;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_addr  = addr_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pixel_uart_sender.sv
// Bench for pixel_uart_sender: RAM and UART models, expected byte
// stream derived from RAM contents, randomized pixels and busy times.
module tb_pixel_uart_sender;

    localparam int NPIX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        tx_busy = 1'b0;
    logic [23:0] rd_data = '0;
    logic [1:0]  rd_addr;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    logic [23:0] ram [NPIX];
    logic [7:0]  got_q [$];
    int          done_cnt = 0;
    int          viol = 0;
    int          cnt = 0;
    int          busy_len = 10;
    bit          rand_len = 1'b0;
    bit          hold = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    pixel_uart_sender #(.PIXEL_COUNT(NPIX)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .tx_busy  (tx_busy),
        .rd_data  (rd_data),
        .rd_addr  (rd_addr),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data valid one cycle after the address
    always @(posedge clk) rd_data <= ram[rd_addr];

    // UART model: latches a byte on tx_start, then stays busy a while
    always @(negedge clk) begin
        if (tx_start) begin
            if (tx_busy) viol++;
            got_q.push_back(tx_data);
            cnt = rand_len ? int'($urandom_range(1, 6)) : busy_len;
        end else if (cnt > 0) begin
            cnt--;
        end
        if (done) done_cnt++;
        tx_busy = (cnt > 0) || hold;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_frame(input string nm, input int restart_at,
                             input int bp_cycles, output int lat);
        logic [7:0] exp_q [$];
        int t;
        lat = -1;
        for (int p = 0; p < NPIX; p++)
            for (int b = 0; b < 3; b++)
                exp_q.push_back(8'((ram[p] >> (8 * b)) & 24'hFF));
        t = 0;
        while (tx_busy && t < 200) begin
            tick();
            t++;
        end
        got_q.delete();
        done_cnt = 0;
        if (bp_cycles > 0) begin
            hold = 1'b1;
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        if (bp_cycles > 0) begin
            repeat (bp_cycles) tick();
            chk({nm, ".bp_hold"}, got_q.size(), 0);
            hold = 1'b0;
            tick();
            tick();
            chk({nm, ".bp_release"}, got_q.size() + 32'(tx_start), 1);
        end
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            tick();
            t++;
            if (lat < 0 && tx_start) lat = t;
            if (t == restart_at) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                t++;
            end
        end
        chk({nm, ".finished"}, 32'(done_cnt != 0), 1);
        repeat (3) tick();
        chk({nm, ".nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s.byte%0d", nm, i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD,
                32'(exp_q[i]));
        chk({nm, ".done_once"}, done_cnt, 1);
        chk({nm, ".busy_low"}, busy, 0);
        chk({nm, ".addr0"}, rd_addr, 0);
        chk({nm, ".no_overlap"}, viol, 0);
    endtask

    initial begin
        int lat;
        int t;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NPIX; i++) ram[i] = 24'($urandom);
        #3 reset = 1'b0;
        #4;
        chk("rst.tx_start", tx_start, 0);
        chk("rst.tx_data", tx_data, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.addr", rd_addr, 0);
        tick();
        reset = 1'b1;
        repeat (20) tick();
        chk("idle.no_tx", got_q.size(), 0);
        chk("idle.addr", rd_addr, 0);
        chk("idle.busy", busy, 0);

        ram[0] = 24'hABCDEF;
        busy_len = 10;
        run_frame("order", 0, 0, lat);
        chk("order.latency", lat, 3);

        ram[0] = 24'h000001;
        ram[1] = 24'h020304;
        ram[2] = 24'hFFFFFF;
        ram[3] = 24'h800000;
        run_frame("full", 0, 0, lat);

        busy_len = 2;
        run_frame("bp", 0, 50, lat);

        run_frame("restart", 20, 0, lat);

        rand_len = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++) ram[i] = 24'($urandom);
            run_frame($sformatf("rand%0d", f), 0, 0, lat);
        end

        rand_len = 1'b0;
        busy_len = 3;
        ram[0] = 24'hABCDEF;
        got_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (got_q.size() < 5 && t < 500) begin
            tick();
            t++;
        end
        chk("mid.reached5", got_q.size(), 5);
        reset = 1'b0;
        #1;
        chk("mid.tx_start", tx_start, 0);
        chk("mid.tx_data", tx_data, 0);
        chk("mid.busy", busy, 0);
        chk("mid.addr", rd_addr, 0);
        repeat (5) tick();
        chk("mid.no_more", got_q.size(), 5);
        reset = 1'b1;
        repeat (3) tick();
        chk("mid.idle", busy, 0);
        run_frame("mid.re", 0, 0, lat);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
